// File: rtl/grey_seq.sv
// Run-control sequencer for the 12-digit grey counter: streamed init load with
// Johnson-code validation, commit pulse, prescaled count enable and digit select/scan.
module grey_seq #(
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned DWELL    = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_load_vld,
  input  logic [5:0]  i_load_data,
  input  logic        i_scan,
  input  logic [7:0]  i_sel,
  output logic [59:0] o_init,
  output logic        o_init_ld,
  output logic        o_cnt_en,
  output logic [7:0]  o_sel,
  output logic        o_busy,
  output logic        o_err,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ARM  = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  localparam logic [15:0] PRE_LAST   = 16'(PRESCALE - 1);
  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

  state_t      r_state;
  logic [59:0] r_shreg;
  logic [3:0]  r_beat;
  logic [15:0] r_pre;
  logic [59:0] r_init;
  logic        r_init_ld;
  logic        r_cnt_en;
  logic        r_err;
  logic        r_scan_d;
  logic [3:0]  r_idx;
  logic [15:0] r_dwell;
  logic [7:0]  r_sel;

  logic [59:0] w_shreg_nxt;
  logic        w_all_ok;
  logic [15:0] w_pre_nxt;

  function automatic logic digit_ok(input logic [4:0] d);
    case (d)
      5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
      5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000: digit_ok = 1'b1;
      default: digit_ok = 1'b0;
    endcase
  endfunction

  assign w_shreg_nxt = {r_shreg[53:0], i_load_data};
  assign w_pre_nxt   = (r_pre == PRE_LAST) ? 16'd0 : r_pre + 16'd1;

  // Validation looks at the value including the beat arriving this cycle.
  always_comb begin
    w_all_ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      w_all_ok = w_all_ok & digit_ok(w_shreg_nxt[i*5 +: 5]);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_beat    <= '0;
      r_pre     <= '0;
      r_init    <= '0;
      r_init_ld <= 1'b0;
      r_cnt_en  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_init_ld <= 1'b0;
      r_cnt_en  <= 1'b0;
      if (i_stop) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_state <= S_LOAD;
              r_beat  <= '0;
              r_shreg <= '0;
              r_err   <= 1'b0;
            end
          end
          S_LOAD: begin
            if (i_start) begin
              r_beat  <= '0;
              r_shreg <= '0;
              r_err   <= 1'b0;
            end else if (i_load_vld) begin
              r_shreg <= w_shreg_nxt;
              r_beat  <= r_beat + 4'd1;
              if (r_beat == 4'd9) begin
                if (w_all_ok) begin
                  r_state <= S_ARM;
                end else begin
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
                end
              end
            end
          end
          S_ARM: begin
            r_init    <= r_shreg;
            r_init_ld <= 1'b1;
            r_pre     <= '0;
            r_cnt_en  <= (PRE_LAST == 16'd0);
            r_state   <= S_RUN;
          end
          S_RUN: begin
            if (i_start) begin
              r_state <= S_LOAD;
              r_beat  <= '0;
              r_shreg <= '0;
              r_err   <= 1'b0;
            end else begin
              r_pre    <= w_pre_nxt;
              r_cnt_en <= (w_pre_nxt == PRE_LAST);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Scan counters only advance while scanning so re-entry always starts at digit 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scan_d <= 1'b0;
      r_idx    <= '0;
      r_dwell  <= '0;
      r_sel    <= '0;
    end else begin
      r_scan_d <= i_scan;
      if (!i_scan) begin
        r_sel <= i_sel;
        if (r_scan_d) begin
          r_idx   <= '0;
          r_dwell <= '0;
        end
      end else begin
        r_sel <= {4'b0000, r_idx};
        if (r_dwell == DWELL_LAST) begin
          r_dwell <= '0;
          r_idx   <= (r_idx == 4'd11) ? 4'd0 : r_idx + 4'd1;
        end else begin
          r_dwell <= r_dwell + 16'd1;
        end
      end
    end
  end

  assign o_init    = r_init;
  assign o_init_ld = r_init_ld;
  assign o_cnt_en  = r_cnt_en;
  assign o_sel     = r_sel;
  assign o_err     = r_err;
  assign o_state   = r_state;
  assign o_busy    = (r_state == S_LOAD) || (r_state == S_ARM);

endmodule

// File: tb/tb_grey_seq.sv
// Directed bench for grey_seq with PRESCALE=4, DWELL=3.
module tb_grey_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_stop, i_load_vld, i_scan;
  logic [5:0]  i_load_data;
  logic [7:0]  i_sel;
  logic [59:0] o_init;
  logic        o_init_ld, o_cnt_en, o_busy, o_err;
  logic [7:0]  o_sel;
  logic [1:0]  o_state;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [59:0] V_ONES = 60'h084210842108421;

  grey_seq #(.PRESCALE(4), .DWELL(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_stop(i_stop),
    .i_load_vld(i_load_vld), .i_load_data(i_load_data), .i_scan(i_scan),
    .i_sel(i_sel), .o_init(o_init), .o_init_ld(o_init_ld), .o_cnt_en(o_cnt_en),
    .o_sel(o_sel), .o_busy(o_busy), .o_err(o_err), .o_state(o_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 64'(o_state), 64'd0);
    chk({tag, "_init"}, 64'(o_init), 64'd0);
    chk({tag, "_init_ld"}, 64'(o_init_ld), 64'd0);
    chk({tag, "_cnt_en"}, 64'(o_cnt_en), 64'd0);
    chk({tag, "_sel"}, 64'(o_sel), 64'd0);
    chk({tag, "_err"}, 64'(o_err), 64'd0);
    chk({tag, "_busy"}, 64'(o_busy), 64'd0);
  endtask

  // Valid load: ends one cycle into RUN (the commit cycle).
  task automatic do_load(input logic [59:0] v);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("start_state", 64'(o_state), 64'd1);
    chk("start_err_clr", 64'(o_err), 64'd0);
    for (int b = 0; b < 10; b++) begin
      i_load_vld  = 1'b1;
      i_load_data = v[59 - 6*b -: 6];
      step();
      chk("beat_state", 64'(o_state), (b == 9) ? 64'd2 : 64'd1);
      chk("beat_busy", 64'(o_busy), 64'd1);
      chk("beat_no_ld", 64'(o_init_ld), 64'd0);
    end
    i_load_vld = 1'b0;
    step();
    chk("run_state", 64'(o_state), 64'd3);
    chk("run_init_ld", 64'(o_init_ld), 64'd1);
    chk("run_init", 64'(o_init), 64'(v));
    chk("run_busy", 64'(o_busy), 64'd0);
    chk("run_cnt_en1", 64'(o_cnt_en), 64'd0);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_load_vld = 1'b0;
    i_load_data = '0; i_scan = 1'b0; i_sel = '0;
    #12;
    chk_reset_vals("rst");
    rst = 1'b0;
    step();

    // Valid load of all-zero digits, then RUN pacing: pulse on RUN cycles 4, 8
    do_load(60'h0);
    for (int k = 2; k <= 9; k++) begin
      step();
      chk("pace_cnt_en", 64'(o_cnt_en), (k % 4 == 0) ? 64'd1 : 64'd0);
      chk("pace_ld_once", 64'(o_init_ld), 64'd0);
    end

    // Stop and start together in RUN: stop wins
    i_start = 1'b1; i_stop = 1'b1;
    step();
    i_start = 1'b0; i_stop = 1'b0;
    chk("stopwin_state", 64'(o_state), 64'd0);
    chk("stopwin_err", 64'(o_err), 64'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("stopwin_cnt_en", 64'(o_cnt_en), 64'd0);
      chk("stopwin_idle", 64'(o_state), 64'd0);
    end

    // Stalled partial load then abort
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      i_load_vld  = (k == 0 || k == 2 || k == 5 || k == 6);
      i_load_data = 6'h3F;
      step();
      chk("stall_state", 64'(o_state), 64'd1);
    end
    i_load_vld = 1'b0;
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    chk("abort_state", 64'(o_state), 64'd0);
    chk("abort_init", 64'(o_init), 64'd0);
    chk("abort_busy", 64'(o_busy), 64'd0);
    do_load(V_ONES);
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;

    // Invalid digit 0 = 00101
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int b = 0; b < 10; b++) begin
      i_load_vld  = 1'b1;
      i_load_data = (b == 9) ? 6'h05 : 6'h00;
      step();
    end
    i_load_vld = 1'b0;
    chk("bad_state", 64'(o_state), 64'd0);
    chk("bad_err", 64'(o_err), 64'd1);
    step();
    chk("bad_no_ld", 64'(o_init_ld), 64'd0);
    chk("bad_init_kept", 64'(o_init), 64'(V_ONES));
    chk("bad_err_sticky", 64'(o_err), 64'd1);

    // Scan: each digit held 3 cycles, wraps after 11
    i_scan = 1'b1;
    for (int k = 0; k < 40; k++) begin
      step();
      chk("scan_sel", 64'(o_sel), 64'((k / 3) % 12));
    end
    i_scan = 1'b0; i_sel = 8'hA5;
    step();
    chk("manual_sel", 64'(o_sel), 64'hA5);
    step();
    chk("manual_sel_hold", 64'(o_sel), 64'hA5);
    i_scan = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rescan_sel", 64'(o_sel), (k < 3) ? 64'd0 : 64'd1);
    end
    i_scan = 1'b0; i_sel = 8'h00;
    step();

    // Follow-up load clears o_err; then async reset mid-RUN with pulse in flight
    do_load(V_ONES);
    step(); step();
    step();
    chk("pre_rst_cnt_en", 64'(o_cnt_en), 64'd1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async");
    #2 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("post_rst_cnt_en", 64'(o_cnt_en), 64'd0);
      chk("post_rst_state", 64'(o_state), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
